// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the 16-bit-write / 8-bit-read FIFO.
//   FIFO_WR_DEPTH   : default depth in 16-bit words
//   FIFO_BYTE_DEPTH : storage depth in bytes (two per word)
//   FIFO_PTR_W      : byte pointer width (wraps modulo FIFO_BYTE_DEPTH)
//   FIFO_CNT_W      : byte count width (must hold 0..FIFO_BYTE_DEPTH)
//   FIFO_WCNT_W     : word count width (must hold 0..FIFO_WR_DEPTH)
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_WR_DEPTH   = 256;
    localparam int FIFO_BYTE_DEPTH = 2 * FIFO_WR_DEPTH;
    localparam int FIFO_PTR_W      = $clog2(FIFO_BYTE_DEPTH);
    localparam int FIFO_CNT_W      = FIFO_PTR_W + 1;
    localparam int FIFO_WCNT_W     = FIFO_PTR_W;

endpackage : fifo_pkg

// File: rtl/sdp_ram_w16_r8.sv
// ---------------------------------------------------------------------------
// sdp_ram_w16_r8
// Simple dual-port RAM: one 16-bit write port, one 8-bit registered read port.
// Bytes are addressed big-endian inside a word: byte address 2k is word k
// bits [15:8], byte address 2k+1 is word k bits [7:0].
//   clk      : clock, rising edge
//   srst     : synchronous active-high reset of the read register only
//   wr_en    : write wr_data to word wr_addr
//   wr_addr  : word address
//   wr_data  : 16-bit write word
//   rd_en    : load the read register from byte address rd_addr
//   rd_addr  : byte address
//   rd_data  : registered read byte, holds while rd_en is low
// ---------------------------------------------------------------------------
module sdp_ram_w16_r8
    import fifo_pkg::*;
#(
    parameter int WR_DEPTH = FIFO_WR_DEPTH
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          wr_en,
    input  logic [$clog2(WR_DEPTH)-1:0]   wr_addr,
    input  logic [15:0]                   wr_data,
    input  logic                          rd_en,
    input  logic [$clog2(WR_DEPTH):0]     rd_addr,
    output logic [7:0]                    rd_data
);

    localparam int WA_W = $clog2(WR_DEPTH);

    logic [15:0] mem [WR_DEPTH];
    logic [15:0] rd_word;
    logic        rd_lo_sel;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Full-word registered read keeps the array a plain block RAM; the byte
    // select is registered alongside so the output mux sits after the RAM.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_word   <= '0;
            rd_lo_sel <= 1'b0;
        end else if (rd_en) begin
            rd_word   <= mem[rd_addr[WA_W:1]];
            rd_lo_sel <= rd_addr[0];
        end
    end

    assign rd_data = rd_lo_sel ? rd_word[7:0] : rd_word[15:8];

endmodule : sdp_ram_w16_r8

// File: rtl/fifo_w16_r8.sv
// ---------------------------------------------------------------------------
// fifo_w16_r8
// Synchronous FIFO, 16-bit words in, bytes out, upper byte of a word first.
//   clk            : clock, rising edge
//   srst           : synchronous active-high reset, priority over wr_en/rd_en
//   din            : write word
//   wr_en          : write request
//   rd_en          : read request
//   dout           : read byte, updated one cycle after an accepted read
//   valid          : dout was updated by an accepted read this cycle
//   full / empty   : registered status flags
//   overflow       : one-cycle pulse for a write rejected because full
//   underflow      : one-cycle pulse for a read rejected because empty
//   wr_data_count  : occupied words, a lone byte counts as a whole word
//   rd_data_count  : occupied bytes
//
// Handshake: wr_en / rd_en are requests with no separate ready; a request is
// accepted in the cycle it is sampled iff its flag (full for writes, empty for
// reads) is low at that edge. Flags always reflect the state before the edge,
// so a same-cycle read never unblocks a write and vice versa.
// ---------------------------------------------------------------------------
module fifo_w16_r8
    import fifo_pkg::*;
#(
    parameter int WR_DEPTH = FIFO_WR_DEPTH
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [15:0] din,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [7:0]  dout,
    output logic        valid,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic        underflow,
    output logic [8:0]  wr_data_count,
    output logic [9:0]  rd_data_count
);

    localparam int BYTE_DEPTH = 2 * WR_DEPTH;
    localparam int PTR_W      = $clog2(BYTE_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int WA_W       = PTR_W - 1;

    // The byte write pointer is always even, so only its word part is kept:
    // byte write pointer == {wr_word_ptr, 1'b0}.
    logic [WA_W-1:0]  wr_word_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] bc_next;
    logic             wr_acc;
    logic             rd_acc;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        bc_next = bc;
        if (wr_acc) begin
            bc_next = bc_next + CNT_W'(2);
        end
        if (rd_acc) begin
            bc_next = bc_next - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_word_ptr <= '0;
            rd_ptr      <= '0;
            bc          <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            valid       <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_word_ptr <= wr_word_ptr + WA_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            bc        <= bc_next;
            // Full means fewer than two free bytes: a whole word no longer fits.
            full      <= (bc_next >= CNT_W'(BYTE_DEPTH - 1));
            empty     <= (bc_next == '0);
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
            valid     <= rd_acc;
        end
    end

    assign rd_data_count = 10'(bc);
    assign wr_data_count = 9'(bc[CNT_W-1:1]) + 9'(bc[0]);

    sdp_ram_w16_r8 #(
        .WR_DEPTH (WR_DEPTH)
    ) u_ram (
        .clk     (clk),
        .srst    (srst),
        .wr_en   (wr_acc),
        .wr_addr (wr_word_ptr),
        .wr_data (din),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

endmodule : fifo_w16_r8

// File: doc/fifo_w16_r8.md
FIFO_W16_R8 -- requirements
Module: fifo_w16_r8

Interface
REQ-001 The block SHALL have parameter WR_DEPTH, default 256, meaning write-side depth in 16-bit words (power of two).
REQ-002 The block SHALL have clk  input  1  clock; all logic on rising edge.
REQ-003 The block SHALL have srst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have din  input  16  write word.
REQ-005 The block SHALL have wr_en  input  1  write request, one word per cycle.
REQ-006 The block SHALL have rd_en  input  1  read request, one byte per cycle.
REQ-007 The block SHALL have dout  output  8  read byte.
REQ-008 The block SHALL have valid  output  1  dout updated this cycle by an accepted read.
REQ-009 The block SHALL have full, empty  output  1 each  status flags.
REQ-010 The block SHALL have overflow, underflow  output  1 each  one-cycle pulse on a rejected write or read.
REQ-011 The block SHALL have wr_data_count  output  9  words occupied, partial words counted as whole.
REQ-012 The block SHALL have rd_data_count  output  10  bytes occupied.

Function
REQ-013 Storage SHALL be 2*WR_DEPTH bytes; an internal byte count bc (0..512) SHALL track occupancy.
REQ-014 An accepted write SHALL store din[15:8] at byte slot wp and din[7:0] at wp+1, so the upper byte is read first.
REQ-015 A write SHALL be accepted iff wr_en=1 and full=0; wp then advances by 2 modulo 512.
REQ-016 A read SHALL be accepted iff rd_en=1 and empty=0; rp then advances by 1 modulo 512.
REQ-017 Read latency SHALL be one cycle: dout and valid=1 appear the cycle after rd_en is sampled. When no read is accepted, dout SHALL hold and valid SHALL be 0.
REQ-018 bc SHALL update as bc + 2*(write accepted) - (read accepted) in the same cycle.
REQ-019 A simultaneous write and read SHALL both be accepted when the flags allow, giving a net bc change of +1.
REQ-020 full SHALL be 1 iff bc >= 511, i.e. fewer than 2 free bytes.
REQ-021 empty SHALL be 1 iff bc == 0.
REQ-022 The flags SHALL be registered and consistent with bc after each edge.
REQ-023 A read SHALL NOT unblock a same-cycle write when full=1, and a write SHALL NOT unblock a same-cycle read when empty=1.
REQ-024 rd_data_count SHALL equal bc.
REQ-025 wr_data_count SHALL equal bc[9:1] + bc[0].
REQ-026 overflow SHALL pulse for 1 cycle when wr_en=1 and full=1; the write is dropped and state is unchanged.
REQ-027 underflow SHALL pulse for 1 cycle when rd_en=1 and empty=1; dout holds and valid=0.
REQ-028 Pointer wrap SHALL be seamless: a word written at slot 510 occupies slots 510 and 511.

Reset
REQ-029 While srst=1 at a clk edge, the block SHALL set wp=0, rp=0, bc=0, dout=8'h00, valid=0, full=0, empty=1, overflow=0, underflow=0 and both counts 0.
REQ-030 srst SHALL take priority over wr_en and rd_en in the same cycle.
REQ-031 srst asserted mid-operation SHALL discard all stored data; RAM contents need not be cleared.
REQ-032 In the first cycle after srst deasserts, the block SHALL accept writes.

Structure
REQ-033 A shared package fifo_pkg SHALL hold the WR_DEPTH default, derived byte depth, and the pointer and count widths.
REQ-034 Storage SHALL be one sub-module, sdp_ram_w16_r8: simple dual-port, 16-bit write port, 8-bit registered read port, inferable as block RAM.
REQ-035 Pointers, bc, flags and pulses SHALL reside in fifo_w16_r8.

Verification
REQ-036 Reset then write 16'hA1B2 and read 2 bytes -> dout 8'hA1 then 8'hB2, with valid high each cycle after the rd_en cycle; empty=1 after the second read.
REQ-037 Write 256 words with no reads -> full=1, wr_data_count=256, rd_data_count=512; a 257th write -> overflow pulse, counts unchanged.
REQ-038 From full, read 1 byte -> bc=511, full stays 1, wr_data_count=256; read a 2nd byte -> full=0 and a write is accepted next cycle.
REQ-039 Empty FIFO with rd_en=1 -> underflow pulse, valid=0, dout holds; wr_en and rd_en together on empty -> write accepted, read rejected, bc=2.
REQ-040 Continuous wr_en every other cycle and rd_en every cycle, run for 600 cycles across pointer wrap -> byte stream equals the written words MSB-first with no loss and bc never exceeds 2.
REQ-041 Fill 100 words, assert srst for 1 cycle mid-stream -> empty=1, counts 0, and the next written word reads back first.
